// File: rtl/conv_encoder_batch_normalization_unit.sv
// Purpose: per-filter batch-norm y = sat((x*p + q) >>> SHIFT) with optional ReLU, (p,q) fetched from weights memory behind a one-entry cache.
// Latency: accept edge to out_valid_o = 2 cycles on a cache hit, 4 cycles on a miss (plus any wm_ready_i wait).
// Backpressure: one sample in flight; in_ready_o only in IDLE, out_data_o/out_valid_o held while !out_ready_i.
module conv_encoder_batch_normalization_unit #(
  parameter int DATA_W = 18,
  parameter int P_W    = 18,
  parameter int Q_W    = 36,
  parameter int OUT_W  = 18,
  parameter int SHIFT  = 8,
  parameter int RELU   = 1,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [SEL_W-1:0]  in_filter_i,
  output logic              wm_start_o,
  output logic [SEL_W-1:0]  wm_filter_sel_o,
  input  logic [P_W-1:0]    wm_p_i,
  input  logic [Q_W-1:0]    wm_q_i,
  input  logic              wm_ready_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [OUT_W-1:0]  out_data_o
);

  localparam int PROD_W = DATA_W + P_W;
  localparam int SUM_W  = ((PROD_W > Q_W) ? PROD_W : Q_W) + 1;
  // Bits of the shifted sum that must all agree with the sign for the value to fit OUT_W.
  localparam int TOP_W  = SUM_W - OUT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_MUL,
    S_ADD,
    S_OUT
  } state_t;

  state_t              state_q;
  logic                in_ready_q;
  logic                wm_start_q;
  logic [SEL_W-1:0]    wm_sel_q;
  logic                out_valid_q;
  logic [OUT_W-1:0]    out_data_q;

  logic [DATA_W-1:0]   x_q;
  logic [SEL_W-1:0]    filt_q;
  logic [PROD_W-1:0]   prod_q;

  // One-entry weight cache: the (p,q) of the most recently fetched filter.
  logic                cache_vld_q;
  logic [SEL_W-1:0]    cache_filt_q;
  logic [P_W-1:0]      cache_p_q;
  logic [Q_W-1:0]      cache_q_q;

  logic                cache_hit;
  logic [PROD_W-1:0]   prod_d;
  logic signed [SUM_W-1:0] sum_d;
  logic signed [SUM_W-1:0] shifted_d;
  logic [TOP_W-1:0]    top_bits;
  logic [OUT_W-1:0]    sat_d;
  logic [OUT_W-1:0]    res_d;

  assign cache_hit = cache_vld_q && (cache_filt_q == in_filter_i);

  // Datapath: full-precision product, sign-extended sum, floor shift, saturation and ReLU.
  always_comb begin
    prod_d    = PROD_W'($signed(x_q)) * PROD_W'($signed(cache_p_q));
    sum_d     = SUM_W'($signed(prod_q)) + SUM_W'($signed(cache_q_q));
    shifted_d = sum_d >>> SHIFT;
    top_bits  = shifted_d[SUM_W-1:OUT_W-1];
    sat_d     = shifted_d[OUT_W-1:0];
    if (!shifted_d[SUM_W-1] && (|top_bits)) begin
      sat_d = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (shifted_d[SUM_W-1] && !(&top_bits)) begin
      sat_d = {1'b1, {(OUT_W-1){1'b0}}};
    end
    res_d = sat_d;
    if ((RELU != 0) && sat_d[OUT_W-1]) begin
      res_d = '0;
    end
  end

  // Control FSM with registered handshake, fetch and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b0;
      wm_start_q   <= 1'b0;
      wm_sel_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      x_q          <= '0;
      filt_q       <= '0;
      prod_q       <= '0;
      cache_vld_q  <= 1'b0;
      cache_filt_q <= '0;
      cache_p_q    <= '0;
      cache_q_q    <= '0;
    end else begin
      wm_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid_i && in_ready_q) begin
            x_q        <= in_data_i;
            filt_q     <= in_filter_i;
            in_ready_q <= 1'b0;
            if (cache_hit) begin
              state_q <= S_MUL;
            end else begin
              state_q    <= S_FETCH;
              wm_start_q <= 1'b1;
              wm_sel_q   <= in_filter_i;
            end
          end
        end
        S_FETCH: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          if (wm_ready_i) begin
            cache_p_q    <= wm_p_i;
            cache_q_q    <= wm_q_i;
            cache_filt_q <= filt_q;
            cache_vld_q  <= 1'b1;
            state_q      <= S_MUL;
          end else begin
            // Memory not ready yet: keep requesting until it answers.
            wm_start_q <= 1'b1;
          end
        end
        S_MUL: begin
          prod_q  <= prod_d;
          state_q <= S_ADD;
        end
        S_ADD: begin
          out_data_q  <= res_d;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o      = in_ready_q;
  assign wm_start_o      = wm_start_q;
  assign wm_filter_sel_o = wm_sel_q;
  assign out_valid_o     = out_valid_q;
  assign out_data_o      = out_data_q;

endmodule
